// File: rtl/sim_uart_pkg.sv
// sim_uart_pkg: register map, output FSM states and a status helper
// shared by the simulation UART transmitter.
package sim_uart_pkg;

   localparam logic [3:0] UART_TXDATA = 4'h0;
   localparam logic [3:0] UART_STATUS = 4'h4;
   localparam logic [3:0] UART_CTRL   = 4'h8;
   localparam logic [3:0] UART_STATS  = 4'hC;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      WAIT
   } uart_state_e;

   // STATUS reports occupancy in a 6-bit field, clamped at 63.
   function automatic logic [5:0] sat63(input logic [31:0] v);
      return (v > 32'd63) ? 6'd63 : v[5:0];
   endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// sim_uart_fifo: byte-wide synchronous FIFO; pointers wrap naturally
// because DEPTH is a power of two, count is one bit wider than the pointers.
module sim_uart_fifo #(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          wr_en;
   logic          rd_en;

   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign head  = mem[rptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // Pointer and occupancy tracking; simultaneous push and pop keep count.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (!wr_en && rd_en) count <= count - 1'b1;
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wptr] <= din;
   end

endmodule

// File: rtl/sim_uart_tx.sv
// sim_uart_tx: MMIO UART transmitter for simulation. Buffers TXDATA writes
// in a FIFO and drains them as one-cycle uart_valid/uart_ch pulses with GAP
// idle cycles between pulses. Defining SIM_UART_STATS_EN adds a 32-bit
// transmitted-character counter readable (low byte) and clearable at 0xC.
module sim_uart_tx
   import sim_uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int GAP   = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wen,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       resp_valid,
   output logic [7:0] resp_rdata,
   output logic       uart_valid,
   output logic [7:0] uart_ch
);

   localparam int AW = $clog2(DEPTH);

   uart_state_e state, state_nx;
   logic        enable;
   logic        acc;
   logic        fifo_push;
   logic        fifo_pop;
   logic [7:0]  head;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic [7:0]  gap_cnt;
   logic [7:0]  rd_data;

   // Only a TXDATA write into a full FIFO stalls; full is the registered
   // count, so a pop in the same cycle does not unblock it.
   assign req_ready = !(req_wen && (req_addr == UART_TXDATA) && full);
   assign acc       = req_valid && req_ready;
   assign fifo_push = acc && req_wen && (req_addr == UART_TXDATA);

   sim_uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .din   (req_wdata),
      .pop   (fifo_pop),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Next-state logic. The character is popped on the edge that enters EMIT
   // (so the registered pulse carries the head), hence "another character
   // behind the one being emitted" reads here as !empty.
   always_comb begin
      state_nx = state;
      fifo_pop = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !empty) begin
               state_nx = EMIT;
               fifo_pop = 1'b1;
            end
         end
         EMIT: begin
            if (GAP > 0) begin
               state_nx = WAIT;
            end else if (enable && !empty) begin
               state_nx = EMIT;
               fifo_pop = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            if (gap_cnt <= 8'd1) begin
               if (enable && !empty) begin
                  state_nx = EMIT;
                  fifo_pop = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, gap counter and the registered character pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         gap_cnt    <= 8'd0;
         uart_valid <= 1'b0;
         uart_ch    <= 8'h00;
      end else begin
         state <= state_nx;
         if (state == EMIT)      gap_cnt <= 8'(GAP);
         else if (state == WAIT) gap_cnt <= gap_cnt - 8'd1;
         uart_valid <= fifo_pop;
         if (fifo_pop) uart_ch <= head;
      end
   end

`ifdef SIM_UART_STATS_EN
   logic [31:0] tx_count;

   // Transmitted-character counter; a clear wins over a coincident pulse.
   always_ff @(posedge clock) begin
      if (reset)
         tx_count <= 32'd0;
      else if (acc && req_wen && (req_addr == UART_STATS))
         tx_count <= 32'd0;
      else if (uart_valid)
         tx_count <= tx_count + 32'd1;
   end
`endif

   // Read data mux; unmapped offsets and TXDATA read as zero.
   always_comb begin
      rd_data = 8'h00;
      case (req_addr)
         UART_STATUS: rd_data = {sat63(32'(count)), empty, full};
         UART_CTRL:   rd_data = {7'b0, enable};
`ifdef SIM_UART_STATS_EN
         UART_STATS:  rd_data = tx_count[7:0];
`endif
         default:     rd_data = 8'h00;
      endcase
   end

   // Control register and one-cycle read response.
   always_ff @(posedge clock) begin
      if (reset) begin
         enable     <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 8'h00;
      end else begin
         resp_valid <= acc && !req_wen;
         if (acc && !req_wen) resp_rdata <= rd_data;
         if (acc && req_wen && (req_addr == UART_CTRL)) enable <= req_wdata[0];
      end
   end

endmodule

// File: tb/tb_sim_uart_tx.sv
// tb_sim_uart_tx: two transmitters (GAP=0 and GAP=3) share one request bus.
// Stimulus pushes expected characters/read data into queues; a negedge
// monitor pops and compares each pulse and response, including pulse timing
// derived from the availability/throughput rules.
module tb_sim_uart_tx;
   import sim_uart_pkg::*;

   typedef struct packed { logic [7:0] ch; int avail; } exp_t;
   typedef struct packed { logic [7:0] d;  int cyc;   } rsp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid, req_wen;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rdy0, rdy3, rv0, rv3, uv0, uv3;
   logic [7:0] rd0, rd3, uc0, uc3;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   last [2];
   int   npulse [2];
   bit   timing_on = 1'b0;
   exp_t q0[$], q3[$];
   rsp_t r0[$], r3[$];

   sim_uart_tx #(.DEPTH(16), .GAP(0)) dut0 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv0), .resp_rdata(rd0), .uart_valid(uv0), .uart_ch(uc0));

   sim_uart_tx #(.DEPTH(16), .GAP(3)) dut3 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv3), .resp_rdata(rd3), .uart_valid(uv3), .uart_ch(uc3));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mon_pulse(input int i, input logic [7:0] ch);
      exp_t e;
      int   gap, exp_c;
      bit   have;
      gap  = (i == 0) ? 0 : 3;
      have = (i == 0) ? (q0.size() != 0) : (q3.size() != 0);
      npulse[i]++;
      if (!have) begin
         vectors++;
         miscompares++;
         $display("FAIL pulse%0d_spurious: got ch %02h want no pulse (cyc %0d)", i, ch, cyc);
      end else begin
         if (i == 0) e = q0.pop_front();
         else        e = q3.pop_front();
         chk($sformatf("pulse%0d_ch", i), ch, e.ch);
         if (timing_on) begin
            exp_c = (e.avail > last[i] + gap + 1) ? e.avail : last[i] + gap + 1;
            chk($sformatf("pulse%0d_cycle", i), cyc, exp_c);
         end
      end
      last[i] = cyc;
   endtask

   task automatic mon_resp(input int i, input logic [7:0] d);
      rsp_t r;
      bit   have;
      have = (i == 0) ? (r0.size() != 0) : (r3.size() != 0);
      if (!have) begin
         vectors++;
         miscompares++;
         $display("FAIL resp%0d_spurious: got %02h want no response", i, d);
      end else begin
         if (i == 0) r = r0.pop_front();
         else        r = r3.pop_front();
         chk($sformatf("resp%0d_data", i), d, r.d);
         chk($sformatf("resp%0d_cycle", i), cyc, r.cyc);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (uv0) mon_pulse(0, uc0);
         if (uv3) mon_pulse(1, uc3);
         if (rv0) mon_resp(0, rd0);
         if (rv3) mon_resp(1, rd3);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         req_valid = 1'b0;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic ok);
      exp_t e;
      @(negedge clock);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_wdata = d;
      #1;
      chk("req_ready0", rdy0, ok);
      chk("req_ready3", rdy3, ok);
      if (ok && a == UART_TXDATA) begin
         e.ch = d; e.avail = cyc + 2;
         q0.push_back(e); q3.push_back(e);
      end
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e3);
      rsp_t r;
      @(negedge clock);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = a; req_wdata = 8'h00;
      r.cyc = cyc + 1;
      r.d = e0; r0.push_back(r);
      r.d = e3; r3.push_back(r);
   endtask

   task automatic wait_drain(input int maxc);
      int n;
      n = 0;
      while ((q0.size() != 0 || q3.size() != 0) && n < maxc) begin
         idle(1);
         n++;
      end
      chk("drain_within_budget", (n < maxc), 1);
      idle(3);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; req_valid = 1'b0;
      q0.delete(); q3.delete(); r0.delete(); r3.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n, p0, p3, sel;
      logic [3:0] ua;
      logic [7:0] b17;
      last[0] = -100; last[1] = -100;
      npulse[0] = 0;  npulse[1] = 0;
      reset = 1'b1; req_valid = 1'b0; req_wen = 1'b1; req_addr = UART_TXDATA; req_wdata = 8'h00;
      repeat (3) @(negedge clock);
      // reset values
      chk("rst_uart_valid0", uv0, 0);  chk("rst_uart_valid3", uv3, 0);
      chk("rst_uart_ch0", uc0, 0);     chk("rst_uart_ch3", uc3, 0);
      chk("rst_resp_valid0", rv0, 0);  chk("rst_resp_valid3", rv3, 0);
      chk("rst_resp_rdata0", rd0, 0);  chk("rst_resp_rdata3", rd3, 0);
      chk("rst_req_ready0", rdy0, 1);  chk("rst_req_ready3", rdy3, 1);
      reset = 1'b0;
      rd(UART_STATUS, 8'h02, 8'h02);
      rd(UART_CTRL, 8'h01, 8'h01);
      idle(3);

      // two back-to-back characters, then three for the gap spacing
      timing_on = 1'b1;
      wr(UART_TXDATA, 8'h48, 1'b1);
      wr(UART_TXDATA, 8'h69, 1'b1);
      wait_drain(50);
      wr(UART_TXDATA, 8'hA1, 1'b1);
      wr(UART_TXDATA, 8'hB2, 1'b1);
      wr(UART_TXDATA, 8'hC3, 1'b1);
      wait_drain(50);

      // fill while disabled, overflow stalls, then drain in order
      timing_on = 1'b0;
      wr(UART_CTRL, 8'h00, 1'b1);
      for (int k = 0; k < 16; k++) wr(UART_TXDATA, 8'($urandom), 1'b1);
      b17 = 8'($urandom);
      wr(UART_TXDATA, b17, 1'b0);
      rd(UART_STATUS, 8'h41, 8'h41);
      wr(UART_CTRL, 8'h01, 1'b1);
      idle(2);
      wr(UART_TXDATA, b17, 1'b1);
      wait_drain(200);

      // clear enable mid-stream
      wr(UART_CTRL, 8'h00, 1'b1);
      for (int k = 0; k < 5; k++) wr(UART_TXDATA, 8'h30 + 8'(k), 1'b1);
      p0 = npulse[0]; p3 = npulse[1];
      wr(UART_CTRL, 8'h01, 1'b1);
      idle(1);
      wr(UART_CTRL, 8'h00, 1'b1);
      idle(12);
      chk("disable_pulses0", npulse[0] - p0, 2);
      chk("disable_pulses3", npulse[1] - p3, 1);
      rd(UART_STATUS, 8'h0C, 8'h10);
      idle(2);
      wr(UART_CTRL, 8'h01, 1'b1);
      wait_drain(100);
      chk("reenable_pulses0", npulse[0] - p0, 5);
      chk("reenable_pulses3", npulse[1] - p3, 5);

      // reset with characters buffered
      wr(UART_CTRL, 8'h00, 1'b1);
      for (int k = 0; k < 4; k++) wr(UART_TXDATA, 8'($urandom), 1'b1);
      do_reset();
      idle(10);
      rd(UART_STATUS, 8'h02, 8'h02);
      rd(UART_CTRL, 8'h01, 8'h01);
      idle(3);

      // randomized traffic with timing checks
      timing_on = 1'b1;
      for (int it = 0; it < 25; it++) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) wr(UART_TXDATA, 8'($urandom), 1'b1);
         ua = 4'($urandom_range(0, 15));
         if (ua[1:0] == 2'b00) ua[0] = 1'b1;
         sel = $urandom_range(0, 3);
         case (sel)
            0:       rd(UART_CTRL, 8'h01, 8'h01);
            1:       rd(UART_TXDATA, 8'h00, 8'h00);
            2:       rd(ua, 8'h00, 8'h00);
            default: wr(ua, 8'($urandom), 1'b1);
         endcase
         idle(4 * n + $urandom_range(0, 4));
      end
      wait_drain(100);

      do_reset();
      idle(2);
`ifdef SIM_UART_STATS_EN
      for (int k = 0; k < 10; k++) wr(UART_TXDATA, 8'h50 + 8'(k), 1'b1);
      wait_drain(100);
      rd(UART_STATS, 8'h0A, 8'h0A);
      wr(UART_STATS, 8'h00, 1'b1);
      rd(UART_STATS, 8'h00, 8'h00);
`else
      wr(UART_TXDATA, 8'h5A, 1'b1);
      wait_drain(50);
      rd(UART_STATS, 8'h00, 8'h00);
`endif
      idle(4);
      chk("resp_queues_empty", r0.size() + r3.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
